mem_port_arbiter: RTL and testbench

Shares the unicycle core's single data-memory port between the CPU load/store path and a host port, such as an image loader or debug/DMA master. The CPU has priority. It is combinationally passed through to memory whenever the arbiter is in its CPU state. A host transfer takes exactly one memory cycle, during which the CPU is stalled. The block sits between the datapath's load/store signals and `data_memory`; `cpu_stall` gates the PC register update.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter_starve_counter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the data-memory port arbiter.
//   arb_state_t      : arbiter FSM state (CPU owns the port / host owns it)
//   DEFAULT_MAX_WAIT : default host wait limit before a forced grant
package mem_arb_pkg;

    typedef enum logic {
        ARB_CPU  = 1'b0,
        ARB_HOST = 1'b1
    } arb_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 20;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 20;
    localparam int unsigned DEFAULT_MAX_WAIT      = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU load/store path, the host port and the
// data-memory port that the arbiter sits between.
//   slave  : arbiter side (takes cpu_*/host_* requests and mem_rdata,
//            drives mem_* strobes, cpu_rdata/cpu_stall, host responses)
//   master : environment side (CPU datapath, host master, data_memory)
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH    = 20,
    parameter int unsigned ADDRESS_WIDTH = 20
);
    // CPU load/store path
    logic                     cpu_re;
    logic                     cpu_we;
    logic                     cpu_be;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_wdata;
    logic [DATA_WIDTH-1:0]    cpu_rdata;
    logic                     cpu_stall;
    // host port
    logic                     host_valid;
    logic                     host_we;
    logic                     host_be;
    logic [ADDRESS_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0]    host_wdata;
    logic                     host_ready;
    logic                     host_rvalid;
    logic [DATA_WIDTH-1:0]    host_rdata;
    // data memory port
    logic                     mem_re;
    logic                     mem_we;
    logic                     mem_be;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport slave (
        input  cpu_re, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_valid, host_we, host_be, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata,
        output mem_re, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_re, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_valid, host_we, host_be, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata,
        input  mem_re, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// starve_counter: saturating count of cycles the host has been kept waiting.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : count one more waiting cycle (holds at MAX_WAIT)
//   clr      : restart from zero (has priority over inc)
//   sat      : count has reached MAX_WAIT
module starve_counter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign sat = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single data-memory port between the CPU
// load/store path (priority, zero-latency pass-through) and a host master
// (one-cycle transfers that stall the CPU).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : mem_port_arbiter_if.slave (cpu_*, host_*, mem_* signals)
// Build option MEM_ARB_STARVE_EN: adds a starvation guard that forces a host
// grant after MAX_WAIT waiting cycles; without it the CPU has strict priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned MAX_WAIT      = DEFAULT_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_t               state;
    logic                     cpu_busy;
    logic                     force_grant;
    logic                     next_host;

    // host request captured at the grant edge and replayed during ARB_HOST,
    // so the host may present its next request while the current one runs
    logic                     hold_we;
    logic                     hold_be;
    logic [ADDRESS_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0]    hold_wdata;

    logic                     host_ready_q;
    logic                     cpu_stall_q;
    logic                     host_rvalid_q;
    logic [DATA_WIDTH-1:0]    host_rdata_q;

    assign cpu_busy = bus.cpu_re | bus.cpu_we;

    // from ARB_CPU the host needs an idle CPU or a forced grant; from ARB_HOST
    // only an idle CPU, so the host never wins twice in a row against the CPU
    assign next_host = (state == ARB_CPU)
                     ? (bus.host_valid & (~cpu_busy | force_grant))
                     : (bus.host_valid & ~cpu_busy);

`ifdef MEM_ARB_STARVE_EN
    logic wait_inc;
    logic wait_clr;

    assign wait_inc = (state == ARB_CPU) & bus.host_valid & ~next_host;
    assign wait_clr = ~bus.host_valid | (state != ARB_CPU) | next_host;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_counter (
        .clk (clk),
        .rst (rst),
        .inc (wait_inc),
        .clr (wait_clr),
        .sat (force_grant)
    );
`else
    assign force_grant = 1'b0;
`endif

    // stall/ready are registered copies of the next state, so they depend on
    // state only and have no combinational path from the host inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ARB_CPU;
            hold_we       <= 1'b0;
            hold_be       <= 1'b0;
            hold_addr     <= '0;
            hold_wdata    <= '0;
            host_ready_q  <= 1'b0;
            cpu_stall_q   <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            state         <= next_host ? ARB_HOST : ARB_CPU;
            host_ready_q  <= next_host;
            cpu_stall_q   <= next_host;
            host_rvalid_q <= (state == ARB_HOST) & ~hold_we;
            if (next_host) begin
                hold_we    <= bus.host_we;
                hold_be    <= bus.host_be;
                hold_addr  <= bus.host_addr;
                hold_wdata <= bus.host_wdata;
            end
            if ((state == ARB_HOST) && !hold_we) begin
                host_rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.mem_re    = bus.cpu_re;
        bus.mem_we    = bus.cpu_we;
        bus.mem_be    = bus.cpu_be;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_rdata = bus.mem_rdata;
        if (state == ARB_HOST) begin
            bus.mem_re    = ~hold_we;
            bus.mem_we    = hold_we;
            bus.mem_be    = hold_be;
            bus.mem_addr  = hold_addr;
            bus.mem_wdata = hold_wdata;
            bus.cpu_rdata = '0;
        end
        // no memory strobes may escape while reset is held
        if (!rst) begin
            bus.mem_re = 1'b0;
            bus.mem_we = 1'b0;
            bus.mem_be = 1'b0;
        end
    end

    assign bus.cpu_stall   = cpu_stall_q;
    assign bus.host_ready  = host_ready_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized bench for mem_port_arbiter.
// Drives CPU and host requests, models data_memory (combinational read,
// posedge write) and predicts read data from a word-level memory scoreboard.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 20;
    localparam int unsigned AW = 20;
    localparam int unsigned MW = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .MAX_WAIT      (MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // data_memory model
    logic [DW-1:0] mem_model [0:255];
    always @(posedge clk) begin
        if (bus.mem_we) mem_model[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem_model[bus.mem_addr[7:0]];

    // expected memory contents, word granularity
    logic [DW-1:0] ref_mem [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_store(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.cpu_we = 1'b1; bus.cpu_be = 1'b1; bus.cpu_addr = addr; bus.cpu_wdata = data;
        #1;
        check("cpu_store_mem_we", bus.mem_we, 1'b1);
        check("cpu_store_mem_addr", bus.mem_addr, addr);
        check("cpu_store_mem_wdata", bus.mem_wdata, data);
        check("cpu_store_stall", bus.cpu_stall, 1'b0);
        tick();
        bus.cpu_we = 1'b0; bus.cpu_be = 1'b0;
        ref_mem[int'(addr)] = data;
    endtask

    task automatic cpu_load(input logic [AW-1:0] addr);
        bus.cpu_re = 1'b1; bus.cpu_addr = addr;
        #1;
        check("cpu_load_mem_re", bus.mem_re, 1'b1);
        check("cpu_load_rdata", bus.cpu_rdata, ref_mem[int'(addr)]);
        check("cpu_load_stall", bus.cpu_stall, 1'b0);
        tick();
        bus.cpu_re = 1'b0;
    endtask

    // single host transfer with the CPU idle; exp_wait = edges to host_ready
    task automatic host_req(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input string tag);
        int n;
        bus.host_valid = 1'b1; bus.host_we = we; bus.host_be = 1'b1;
        bus.host_addr = addr; bus.host_wdata = data;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.host_ready && n < 200);
        check({tag, "_latency"}, n, 1);
        check({tag, "_stall"}, bus.cpu_stall, 1'b1);
        check({tag, "_mem_we"}, bus.mem_we, we);
        check({tag, "_mem_addr"}, bus.mem_addr, addr);
        check({tag, "_cpu_rdata"}, bus.cpu_rdata, '0);
        bus.host_valid = 1'b0;
        if (we) ref_mem[int'(addr)] = data;
        tick();
        check({tag, "_stall_off"}, bus.cpu_stall, 1'b0);
        check({tag, "_rvalid"}, bus.host_rvalid, !we);
        if (!we) check({tag, "_rdata"}, bus.host_rdata, ref_mem[int'(addr)]);
        tick();
        check({tag, "_rvalid_pulse"}, bus.host_rvalid, 1'b0);
    endtask

    initial begin
        int n;
        int seen;
        logic [DW-1:0] d [4];
        logic [AW-1:0] a;
        logic [DW-1:0] v;

        bus.cpu_re = 1'b0; bus.cpu_we = 1'b1; bus.cpu_be = 1'b1;
        bus.cpu_addr = 20'h00123; bus.cpu_wdata = 20'h00456;
        bus.host_valid = 1'b0; bus.host_we = 1'b0; bus.host_be = 1'b0;
        bus.host_addr = '0; bus.host_wdata = '0;
        #2;
        // reset state, with CPU strobes asserted to show gating
        check("rst_ready", bus.host_ready, 1'b0);
        check("rst_rvalid", bus.host_rvalid, 1'b0);
        check("rst_rdata", bus.host_rdata, '0);
        check("rst_stall", bus.cpu_stall, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_re", bus.mem_re, 1'b0);
        check("rst_mem_be", bus.mem_be, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 20'h00123);
        check("rst_mem_wdata", bus.mem_wdata, 20'h00456);
        bus.cpu_we = 1'b0; bus.cpu_be = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // CPU store then load back
        cpu_store(20'h00010, 20'h0ABCD);
        cpu_load(20'h00010);
        check("cpu_load_const", ref_mem[16], 20'h0ABCD);

        // host read with CPU idle
        host_req(1'b0, 20'h00010, '0, "host_read");

        // contention
        cpu_store(20'h00020, 20'h00111);
`ifdef MEM_ARB_STARVE_EN
        bus.cpu_re = 1'b1; bus.cpu_addr = 20'h00020;
        bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 20'h00020;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.host_ready && n < 200);
        check("forced_latency", n, MW + 1);
        check("forced_stall", bus.cpu_stall, 1'b1);
        tick();
        check("forced_no_second_grant", bus.host_ready, 1'b0);
        check("forced_stall_off", bus.cpu_stall, 1'b0);
        check("forced_rvalid", bus.host_rvalid, 1'b1);
        check("forced_rdata", bus.host_rdata, 20'h00111);
        bus.host_valid = 1'b0; bus.cpu_re = 1'b0;
`else
        bus.cpu_we = 1'b1; bus.cpu_be = 1'b1;
        bus.cpu_addr = 20'h00020; bus.cpu_wdata = 20'h00111;
        bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 20'h00020;
        seen = 0;
        repeat (100) begin
            tick();
            if (bus.host_ready || bus.cpu_stall) seen++;
        end
        check("starve_no_grant", seen, 0);
        bus.cpu_we = 1'b0; bus.cpu_be = 1'b0;
        tick();
        check("starve_grant_after_drop", bus.host_ready, 1'b1);
        bus.host_valid = 1'b0;
        tick();
        check("starve_rvalid", bus.host_rvalid, 1'b1);
        check("starve_rdata", bus.host_rdata, 20'h00111);
`endif
        tick();

        // simultaneous CPU and host requests: CPU first
        bus.cpu_re = 1'b1; bus.cpu_addr = 20'h00010;
        bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 20'h00020;
        #1;
        check("simul_cpu_rdata", bus.cpu_rdata, ref_mem[16]);
        check("simul_mem_addr", bus.mem_addr, 20'h00010);
        tick();
        check("simul_host_waits", bus.host_ready, 1'b0);
        bus.cpu_re = 1'b0;
        tick();
        check("simul_host_grant", bus.host_ready, 1'b1);
        bus.host_valid = 1'b0;
        tick();
        check("simul_rdata", bus.host_rdata, ref_mem[32]);

        // back-to-back host writes to 0..3
        foreach (d[i]) d[i] = DW'($urandom);
        bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_be = 1'b1;
        bus.host_addr = '0; bus.host_wdata = d[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b2b_ready", bus.host_ready, 1'b1);
            check("b2b_mem_addr", bus.mem_addr, AW'(i));
            check("b2b_mem_wdata", bus.mem_wdata, d[i]);
            ref_mem[i] = d[i];
            if (i < 3) begin
                bus.host_addr = AW'(i + 1); bus.host_wdata = d[i + 1];
            end else begin
                bus.host_valid = 1'b0;
            end
        end
        tick();
        check("b2b_release", bus.host_ready, 1'b0);
        for (int i = 0; i < 4; i++) cpu_load(AW'(i));

        // reset during ARB_HOST aborts the transfer
        bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 20'h00010;
        tick();
        check("abort_pre_ready", bus.host_ready, 1'b1);
        #2 rst = 1'b0;
        bus.host_valid = 1'b0;
        #1;
        check("abort_ready", bus.host_ready, 1'b0);
        check("abort_stall", bus.cpu_stall, 1'b0);
        check("abort_mem_re", bus.mem_re, 1'b0);
        check("abort_mem_we", bus.mem_we, 1'b0);
        tick();
        check("abort_no_rvalid", bus.host_rvalid, 1'b0);
        rst = 1'b1;
        tick();
        host_req(1'b0, 20'h00010, '0, "after_reset");

        // randomized mix of CPU and host transfers against the scoreboard
        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom_range(0, 15)) + 20'h00040;
            v = DW'($urandom);
            case ($urandom_range(0, 3))
                0: cpu_store(a, v);
                1: host_req(1'b1, a, v, "rand_hwrite");
                2: if (ref_mem.exists(int'(a))) cpu_load(a); else cpu_store(a, v);
                default: if (ref_mem.exists(int'(a))) host_req(1'b0, a, '0, "rand_hread");
                         else host_req(1'b1, a, v, "rand_hwrite");
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
